// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multicycle IF/ID/EX/MEM/WB stage sequencer
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   run          fetch enable, only looked at while in IF
//   op_code      IR opcode field, valid from ID onward (latched in ID)
//   mem_ready    memory access completes this cycle (IF and MEM handshake)
//   next_state   registered stage code IF=0 ID=1 EX=2 MEM=3 WB=4
//   instr_done   1-cycle pulse in the final stage of a retired instruction
//   illegal_op   1-cycle pulse when ID sees an undefined opcode
//   mem_timeout  sticky flag, set on a memory stall timeout abort
//   instr_count  retired-instruction counter, wraps modulo 2^CNT_W
module stage_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       op_code,
  input  logic             mem_ready,
  output logic [2:0]       next_state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } stage_e;

  // The counter only has to reach MEM_TIMEOUT-1: the stall cycle seen with
  // that value is the MEM_TIMEOUT-th one and triggers the abort.
  localparam int                WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
  localparam bit                TO_EN      = (MEM_TIMEOUT > 0);

  stage_e            state;
  stage_e            state_nxt;
  logic [5:0]        op_latch;
  logic [5:0]        cur_op;
  logic [WAIT_W-1:0] wait_cnt;
  logic              stall;
  logic              timeout_hit;
  logic              is_alu, is_lw, is_st, is_br, is_jmp, is_rp, is_pop;

  assign next_state = state;

  // In ID the opcode is being latched on this very edge, so the path
  // decision there must look at the live field; later stages use the latch.
  always_comb begin
    cur_op = (state == ST_ID) ? op_code : op_latch;
    is_alu = (cur_op <= 6'd4);
    is_lw  = (cur_op == 6'd5)  || (cur_op == 6'd6);
    is_st  = (cur_op == 6'd7)  || (cur_op == 6'd13);
    is_br  = (cur_op[5:2] == 4'b0010);
    is_jmp = (cur_op == 6'd12);
    is_rp  = (cur_op == 6'd14) || (cur_op == 6'd15);
    is_pop = (cur_op == 6'd16);
  end

  // A stall cycle never changes stage on its own, so "cleared on stage
  // change" reduces to "cleared whenever this is not a stall cycle".
  assign stall       = ((state == ST_IF) || (state == ST_MEM)) && !mem_ready;
  assign timeout_hit = TO_EN && stall && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    state_nxt  = state;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      ST_IF: begin
        if (run && mem_ready) state_nxt = ST_ID;
      end
      ST_ID: begin
        if (is_alu || is_lw || is_st || is_br) begin
          state_nxt = ST_EX;
        end else if (is_rp || is_pop) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt  = ST_IF;
          instr_done = is_jmp;
          illegal_op = !is_jmp;
        end
      end
      ST_EX: begin
        if (is_alu) begin
          state_nxt = ST_WB;
        end else if (is_lw || is_st) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt  = ST_IF;
          instr_done = 1'b1;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (is_lw || is_pop) begin
            state_nxt = ST_WB;
          end else begin
            state_nxt  = ST_IF;
            instr_done = 1'b1;
          end
        end else if (timeout_hit) begin
          state_nxt = ST_IF;
        end
      end
      ST_WB: begin
        state_nxt  = ST_IF;
        instr_done = 1'b1;
      end
      default: begin
        // Upset into an unused code: back to fetch, no pulses.
        state_nxt = ST_IF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IF;
      op_latch    <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ID) op_latch <= op_code;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
      if (timeout_hit) mem_timeout <= 1'b1;
      if (!stall || timeout_hit) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - self-checking bench for stage_sequencer
module tb_stage_sequencer;
  localparam int CW = 4;
  localparam int TO = 4;
  localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_MEM = 3, S_WB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [5:0]    op_code = '0;
  logic          mem_ready = 1'b1;
  logic [2:0]    next_state;
  logic          instr_done;
  logic          illegal_op;
  logic          mem_timeout;
  logic [CW-1:0] instr_count;

  stage_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .op_code(op_code), .mem_ready(mem_ready),
    .next_state(next_state), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int e_cnt = 0;

  // Reference model: an instruction is a list of stages looked up from the
  // opcode table; the list is consumed one stage per advancing cycle.
  int m_stage, m_wait, m_cnt;
  int m_path[$];
  bit m_to, m_done, m_ill;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b1; op_code = '0;
    tick();
    tick();
    rst_n = 1'b1;
    m_stage = S_IF; m_wait = 0; m_cnt = 0; m_to = 1'b0; m_path = {};
    e_cnt = 0;
  endtask

  task automatic load_path(input logic [5:0] op);
    m_path = {};
    if (op <= 6'd4)                      m_path = {S_EX, S_WB};
    else if (op == 6'd5 || op == 6'd6)   m_path = {S_EX, S_MEM, S_WB};
    else if (op == 6'd7 || op == 6'd13)  m_path = {S_EX, S_MEM};
    else if (op >= 6'd8 && op <= 6'd11)  m_path = {S_EX};
    else if (op == 6'd14 || op == 6'd15) m_path = {S_MEM};
    else if (op == 6'd16)                m_path = {S_MEM, S_WB};
  endtask

  task automatic pop_stage(output int s);
    if (m_path.size() > 0) s = m_path.pop_front();
    else                   s = S_IF;
  endtask

  task automatic model_step(input bit r, input logic [5:0] op, input bit rdy);
    int nxt;
    bit timed, illeg;
    nxt = m_stage; timed = 1'b0; illeg = 1'b0;
    case (m_stage)
      S_IF:  if (r && rdy) nxt = S_ID;
      S_ID:  begin
        if (op > 6'd16) begin
          illeg = 1'b1; nxt = S_IF;
        end else begin
          load_path(op); pop_stage(nxt);
        end
      end
      S_MEM: if (rdy) pop_stage(nxt);
      default: pop_stage(nxt);
    endcase
    if ((m_stage == S_IF || m_stage == S_MEM) && !rdy) begin
      m_wait++;
      if (m_wait >= TO) begin
        timed = 1'b1; m_to = 1'b1; nxt = S_IF; m_wait = 0;
      end
    end else begin
      m_wait = 0;
    end
    m_ill  = illeg;
    m_done = (nxt == S_IF) && (m_stage != S_IF) && !illeg && !timed;
    if (m_done) m_cnt++;
    m_stage = nxt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; op_code = 6'd1;
    tick();
    tick();
    total++; if (next_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", next_state); end
    total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", instr_done); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal_op); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
    total++; if (instr_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    rst_n = 1'b1; run = 1'b0; e_cnt = 0;
  endtask

  task automatic test_add();
    int es[4] = '{1, 2, 4, 0};
    bit ed[4] = '{0, 0, 0, 1};
    run = 1'b1; mem_ready = 1'b1; op_code = 6'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (instr_done !== ed[i]) begin bad++; $display("FAIL add_done[%0d] got=%b exp=%b", i, instr_done, ed[i]); end
      tick();
      total++; if (next_state !== 3'(es[i])) begin bad++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, next_state, es[i]); end
      if (i == 0) run = 1'b0;
      if (i == 1) op_code = 6'h3f;
    end
    e_cnt++;
    total++; if (instr_count !== CW'(e_cnt)) begin bad++; $display("FAIL add_count got=%0d exp=%0d", instr_count, CW'(e_cnt)); end
    tick();
    total++; if (next_state !== 3'd0) begin bad++; $display("FAIL add_hold got=%0d exp=0", next_state); end
  endtask

  task automatic test_lw_stall();
    int es[8]  = '{1, 2, 3, 3, 3, 3, 4, 0};
    bit rdy[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    bit ed[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    run = 1'b1; op_code = 6'd5;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      total++; if (instr_done !== ed[i]) begin bad++; $display("FAIL lw_done[%0d] got=%b exp=%b", i, instr_done, ed[i]); end
      tick();
      total++; if (next_state !== 3'(es[i])) begin bad++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, next_state, es[i]); end
      if (i == 0) run = 1'b0;
      if (i == 1) op_code = 6'd12;
    end
    mem_ready = 1'b1;
    e_cnt++;
    total++; if (instr_count !== CW'(e_cnt)) begin bad++; $display("FAIL lw_count got=%0d exp=%0d", instr_count, CW'(e_cnt)); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL lw_timeout got=%b exp=0", mem_timeout); end
  endtask

  task automatic test_illegal_then_beq();
    int es[3] = '{1, 2, 0};
    bit ed[3] = '{0, 0, 1};
    run = 1'b1; mem_ready = 1'b1; op_code = 6'h3f;
    #1;
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_if got=%b exp=0", illegal_op); end
    tick();
    total++; if (next_state !== 3'd1) begin bad++; $display("FAIL ill_state_id got=%0d exp=1", next_state); end
    run = 1'b0;
    #1;
    total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL ill_pulse got=%b exp=1", illegal_op); end
    total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL ill_done got=%b exp=0", instr_done); end
    tick();
    total++; if (next_state !== 3'd0) begin bad++; $display("FAIL ill_state_if got=%0d exp=0", next_state); end
    #1;
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL ill_single got=%b exp=0", illegal_op); end
    total++; if (instr_count !== CW'(e_cnt)) begin bad++; $display("FAIL ill_count got=%0d exp=%0d", instr_count, CW'(e_cnt)); end
    run = 1'b1; op_code = 6'h0a;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (instr_done !== ed[i]) begin bad++; $display("FAIL beq_done[%0d] got=%b exp=%b", i, instr_done, ed[i]); end
      tick();
      total++; if (next_state !== 3'(es[i])) begin bad++; $display("FAIL beq_state[%0d] got=%0d exp=%0d", i, next_state, es[i]); end
      if (i == 0) run = 1'b0;
    end
    e_cnt++;
    total++; if (instr_count !== CW'(e_cnt)) begin bad++; $display("FAIL beq_count got=%0d exp=%0d", instr_count, CW'(e_cnt)); end
  endtask

  task automatic test_jmp_wrap();
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; op_code = 6'd12;
    for (int k = 0; k < 16; k++) begin
      #1;
      total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL jmp_done_if[%0d] got=%b exp=0", k, instr_done); end
      tick();
      total++; if (next_state !== 3'd1) begin bad++; $display("FAIL jmp_id[%0d] got=%0d exp=1", k, next_state); end
      #1;
      total++; if (instr_done !== 1'b1) begin bad++; $display("FAIL jmp_done_id[%0d] got=%b exp=1", k, instr_done); end
      tick();
      total++; if (next_state !== 3'd0) begin bad++; $display("FAIL jmp_if[%0d] got=%0d exp=0", k, next_state); end
      e_cnt++;
      total++; if (instr_count !== CW'(e_cnt)) begin bad++; $display("FAIL jmp_count[%0d] got=%0d exp=%0d", k, instr_count, CW'(e_cnt)); end
    end
    run = 1'b0;
  endtask

  task automatic test_sw_timeout();
    int es[7] = '{1, 2, 3, 3, 3, 3, 0};
    // s=0: ready arrives on the limit cycle (ready wins); s=1: never arrives.
    for (int s = 0; s < 2; s++) begin
      run = 1'b1; mem_ready = 1'b1; op_code = 6'd7;
      for (int i = 0; i < 7; i++) begin
        mem_ready = (i < 3) || (i == 6 && s == 0);
        #1;
        total++; if (instr_done !== (i == 6 && s == 0)) begin bad++; $display("FAIL sw%0d_done[%0d] got=%b", s, i, instr_done); end
        tick();
        total++; if (next_state !== 3'(es[i])) begin bad++; $display("FAIL sw%0d_state[%0d] got=%0d exp=%0d", s, i, next_state, es[i]); end
        total++; if (mem_timeout !== (i == 6 && s == 1)) begin bad++; $display("FAIL sw%0d_flag[%0d] got=%b", s, i, mem_timeout); end
        if (i == 0) run = 1'b0;
      end
      mem_ready = 1'b1;
      if (s == 0) e_cnt++;
      total++; if (instr_count !== CW'(e_cnt)) begin bad++; $display("FAIL sw%0d_count got=%0d exp=%0d", s, instr_count, CW'(e_cnt)); end
    end
    run = 1'b1; op_code = 6'd1;
    tick();
    run = 1'b0;
    tick(); tick(); tick();
    e_cnt++;
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", mem_timeout); end
    total++; if (instr_count !== CW'(e_cnt)) begin bad++; $display("FAIL timeout_add_count got=%0d exp=%0d", instr_count, CW'(e_cnt)); end
  endtask

  task automatic test_async_reset();
    run = 1'b1; mem_ready = 1'b1; op_code = 6'd16;
    tick();
    run = 1'b0;
    tick();
    mem_ready = 1'b0;
    tick();
    total++; if (next_state !== 3'd3) begin bad++; $display("FAIL areset_pre got=%0d exp=3", next_state); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (next_state !== 3'd0) begin bad++; $display("FAIL areset_state got=%0d exp=0", next_state); end
    total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL areset_done got=%b exp=0", instr_done); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL areset_illegal got=%b exp=0", illegal_op); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL areset_timeout got=%b exp=0", mem_timeout); end
    total++; if (instr_count !== '0) begin bad++; $display("FAIL areset_count got=%0d exp=0", instr_count); end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; mem_ready = 1'b1; e_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (next_state !== 3'd0) begin bad++; $display("FAIL areset_hold[%0d] got=%0d exp=0", i, next_state); end
    end
  endtask

  task automatic test_random();
    int low_pct;
    for (int ep = 0; ep < 6; ep++) begin
      apply_reset();
      low_pct = 15 + ep * 10;
      for (int c = 0; c < 200; c++) begin
        run       = ($urandom_range(0, 9) < 8);
        mem_ready = ($urandom_range(0, 99) >= low_pct);
        op_code   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 16));
        model_step(run, op_code, mem_ready);
        #1;
        total++; if (instr_done !== m_done) begin bad++; $display("FAIL rnd_done ep%0d c%0d got=%b exp=%b", ep, c, instr_done, m_done); end
        total++; if (illegal_op !== m_ill) begin bad++; $display("FAIL rnd_illegal ep%0d c%0d got=%b exp=%b", ep, c, illegal_op, m_ill); end
        tick();
        total++; if (next_state !== 3'(m_stage)) begin bad++; $display("FAIL rnd_state ep%0d c%0d got=%0d exp=%0d", ep, c, next_state, m_stage); end
        total++; if (instr_count !== CW'(m_cnt)) begin bad++; $display("FAIL rnd_count ep%0d c%0d got=%0d exp=%0d", ep, c, instr_count, CW'(m_cnt)); end
        total++; if (mem_timeout !== m_to) begin bad++; $display("FAIL rnd_timeout ep%0d c%0d got=%b exp=%b", ep, c, mem_timeout, m_to); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_illegal_then_beq();
    test_jmp_wrap();
    test_sw_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multicycle stage FSM that generates the next_state stage code consumed by control_unit.
- Walks each instruction through IF/ID/EX/MEM/WB, skipping stages by opcode.
- Stalls IF and MEM on a memory-ready handshake and aborts on memory timeout.
- Flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- MEM_TIMEOUT, 0, max stall cycles in IF/MEM before abort; 0 disables timeout.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  fetch enable; sampled only in IF.
- op_code  input  6  IR opcode field; valid from ID onward.
- mem_ready  input  1  memory access complete this cycle.
- next_state  output  3  registered stage code: IF=0, ID=1, EX=2, MEM=3, WB=4.
- instr_done  output  1  1-cycle pulse on the final stage of a retired instruction.
- illegal_op  output  1  1-cycle pulse when ID sees an undefined opcode.
- mem_timeout  output  1  sticky; set on timeout abort, cleared only by reset.
- instr_count  output  CNT_W  retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0), all immediate, including mid-instruction:
  - next_state=IF, instr_done=0, illegal_op=0, mem_timeout=0, instr_count=0.
  - Latched opcode=0, wait counter=0.
- IF:
  - Advance to ID only when run=1 and mem_ready=1; otherwise hold.
- ID:
  - Latch op_code into an internal register; all later decisions use the latch.
  - Next stage is chosen by the latched opcode path below.
- Paths (stages after ID):
  - 000000-000100 (AND/ADD/SUB/ANDI/ADDI): EX, WB, IF.
  - 000101, 000110 (LW, LW.POI): EX, MEM, WB, IF.
  - 000111 (SW), 001101 (CALL): EX, MEM, IF.
  - 0010xx (BGT/BLT/BEQ/BNE): EX, IF.
  - 001100 (JMP): IF.
  - 001110 (RET), 001111 (PUSH): MEM, IF.
  - 010000 (POP): MEM, WB, IF.
  - Any other opcode: IF; illegal_op pulses on the ID->IF cycle; not counted as retired.
- EX and WB always take exactly 1 cycle.
- MEM:
  - Hold while mem_ready=0.
  - Leave on the cycle mem_ready=1.
- Retirement:
  - instr_done=1 during the cycle whose posedge returns next_state to IF from a legal instruction.
  - instr_count increments on that same edge.
- Wait counter:
  - Counts consecutive cycles in IF or MEM with mem_ready=0.
  - Clears on any stage change or when mem_ready=1.
- Timeout (MEM_TIMEOUT>0):
  - When the wait counter reaches MEM_TIMEOUT with mem_ready still 0: set mem_timeout, force next_state=IF.
  - No instr_done pulse and no count increment.
  - A timeout in IF itself stays in IF and only sets the flag.
  - If mem_ready=1 on the same cycle the limit is reached, ready wins and no timeout occurs.
- run deassert:
  - Mid-instruction, it has no effect; the instruction completes and the FSM then holds in IF.
- Unused encodings 5-7 (glitch/upset) recover to IF on the next edge, with no pulse.
- Stage latencies with mem_ready=1 (cycles from IF to the next IF):
  - ALU: 4.
  - LW: 5.
  - SW/CALL: 4.
  - Branch: 3.
  - JMP: 2.
  - RET/PUSH: 3.
  - POP: 4.

Test Plan:
- ADD (000001), mem_ready=1, run=1 -> next_state 0,1,2,4,0; instr_done high in the WB cycle; instr_count=1.
- LW (000101), mem_ready=0 for 3 cycles in MEM -> next_state 0,1,2,3,3,3,3,4,0; one instr_done; count increments by 1.
- MEM_TIMEOUT=4, SW (000111), mem_ready held 0 in MEM -> after 4 MEM cycles mem_timeout=1 and next_state=0; count unchanged; mem_timeout stays 1 through a later ADD.
- op_code 111111 -> next_state 0,1,0; illegal_op pulses once; instr_done=0; count unchanged. Then BEQ (001010) -> 0,1,2,0.
- rst_n low asynchronously during POP MEM stage -> next_state=0 and all outputs 0 without waiting for a clk edge; run=0 after release -> holds IF.
- CNT_W=4, 16 back-to-back JMP (001100) -> next_state alternates 0,1; instr_count wraps from 15 to 0.
